mat_operand_loader: RTL and testbench

MAT_OPERAND_LOADER -- requirements
Module: mat_operand_loader

---
 rtl/mat_operand_loader.sv | 130 +++++++++++++
 tb/tb_mat_operand_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_operand_loader.sv
// Loads operand A then operand B (row-major, one 32-bit word per accept) and holds both
// for the adder until en_ack. Framing check on s_last is built when MAT_LOADER_FRAME_CHECK_EN is defined.
module mat_operand_loader #(
    parameter int RSIZE = 2,
    parameter int CSIZE = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [31:0]               s_data,
    input  logic                      s_last,
    output logic [RSIZE*CSIZE*32-1:0] in1,
    output logic [RSIZE*CSIZE*32-1:0] in2,
    output logic                      en,
    input  logic                      en_ack,
    output logic [15:0]               load_cnt,
    output logic                      err
);
    localparam int DATA_W = 32;
    localparam int N      = RSIZE * CSIZE;
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             last_word;

    assign accept    = s_valid && s_ready;
    assign last_word = (idx == IDX_LAST);

    // s_ready and en are registered copies of the next state, so s_ready stays low
    // through reset and only rises on the first edge after rst_n releases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOAD_A;
            idx      <= '0;
            s_ready  <= 1'b0;
            en       <= 1'b0;
            load_cnt <= '0;
        end else if (flush) begin
            state   <= LOAD_A;
            idx     <= '0;
            s_ready <= 1'b1;
            en      <= 1'b0;
        end else begin
            case (state)
                LOAD_A, LOAD_B: begin
                    s_ready <= 1'b1;
                    if (accept) begin
                        if (last_word) begin
                            idx <= '0;
                            if (state == LOAD_A) begin
                                state <= LOAD_B;
                            end else begin
                                state   <= HOLD;
                                s_ready <= 1'b0;
                                en      <= 1'b1;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (en_ack) begin
                        state    <= LOAD_A;
                        s_ready  <= 1'b1;
                        en       <= 1'b0;
                        load_cnt <= load_cnt + 16'd1;
                    end
                end
                default: begin
                    state   <= LOAD_A;
                    idx     <= '0;
                    s_ready <= 1'b1;
                    en      <= 1'b0;
                end
            endcase
        end
    end

    // Word idx lands at bit offset idx*32, which is (row*CSIZE+col)*32 for row-major order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in1 <= '0;
            in2 <= '0;
        end else if (!flush && accept) begin
            for (int i = 0; i < N; i++) begin
                if (idx == IDX_W'(i)) begin
                    if (state == LOAD_A) begin
                        in1[i*DATA_W +: DATA_W] <= s_data;
                    end else if (state == LOAD_B) begin
                        in2[i*DATA_W +: DATA_W] <= s_data;
                    end
                end
            end
        end
    end

`ifdef MAT_LOADER_FRAME_CHECK_EN
    logic frame_end;

    assign frame_end = (state == LOAD_B) && last_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (flush) begin
            err <= 1'b0;
        end else if (accept && (s_last != frame_end)) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_s_last;

    assign unused_s_last = s_last;
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_mat_operand_loader.sv
// Bench for mat_operand_loader: 2x3 instance (directed table, flush, framing, reset, random)
// and 1x1 instance (extreme data and load_cnt wrap).
module tb_mat_operand_loader;
    localparam int R = 2;
    localparam int C = 3;
    localparam int N = R * C;
    localparam int W = N * 32;

`ifdef MAT_LOADER_FRAME_CHECK_EN
    localparam bit FC = 1'b1;
`else
    localparam bit FC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         fl, sv, srdy, sl, en, ack, err;
    logic [31:0]  sd;
    logic [W-1:0] i1, i2;
    logic [15:0]  cnt;

    logic         fl1, sv1, srdy1, sl1, en1, ack1, err1;
    logic [31:0]  sd1, i1_1, i2_1;
    logic [15:0]  cnt1;

    mat_operand_loader #(.RSIZE(R), .CSIZE(C)) dut (
        .clk(clk), .rst_n(rst_n), .flush(fl), .s_valid(sv), .s_ready(srdy),
        .s_data(sd), .s_last(sl), .in1(i1), .in2(i2), .en(en), .en_ack(ack),
        .load_cnt(cnt), .err(err)
    );

    mat_operand_loader #(.RSIZE(1), .CSIZE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(fl1), .s_valid(sv1), .s_ready(srdy1),
        .s_data(sd1), .s_last(sl1), .in1(i1_1), .in2(i2_1), .en(en1), .en_ack(ack1),
        .load_cnt(cnt1), .err(err1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference model: position within the current operand pair (0..2N-1 loading, 2N = holding).
    logic [31:0] m1 [N];
    logic [31:0] m2 [N];
    int          pos;
    bit          mrdy, merr;
    logic [15:0] mcnt;

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m1[k] = '0;
            m2[k] = '0;
        end
        pos = 0; mrdy = 1'b0; merr = 1'b0; mcnt = '0;
    endtask

    task automatic model_edge(input bit v, input logic [31:0] d, input bit last, input bit a, input bit f);
        if (f) begin
            pos = 0; merr = 1'b0; mrdy = 1'b1;
        end else if (pos == 2*N) begin
            if (a) begin
                pos = 0;
                mcnt = mcnt + 16'd1;
            end
        end else begin
            if (v && mrdy) begin
                if (pos < N) m1[pos] = d;
                else         m2[pos-N] = d;
                if (FC && (last != (pos == 2*N-1))) merr = 1'b1;
                pos++;
            end
            mrdy = 1'b1;
        end
    endtask

    function automatic logic [W-1:0] pack(input bit second);
        logic [W-1:0] p;
        for (int k = 0; k < N; k++) p[k*32 +: 32] = second ? m2[k] : m1[k];
        return p;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".s_ready"}, srdy, mrdy && (pos < 2*N));
        check({tag, ".en"}, en, pos == 2*N);
        check({tag, ".load_cnt"}, cnt, mcnt);
        check({tag, ".err"}, err, merr);
        check({tag, ".in1"}, i1, pack(1'b0));
        check({tag, ".in2"}, i2, pack(1'b1));
    endtask

    task automatic cyc(input string tag, input bit v, input logic [31:0] d, input bit last,
                       input bit a, input bit f);
        sv = v; sd = d; sl = last; ack = a; fl = f;
        @(posedge clk); #1;
        model_edge(v, d, last, a, f);
        compare_all(tag);
    endtask

    task automatic tick1();
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit          v;
        logic [31:0] d;
        bit          last;
        bit          a;
        bit          exp_rdy;
        bit          exp_en;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl [19];

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] e1, e2;

        for (int i = 0; i < 19; i++) begin
            tbl[i].v       = 1'b1;
            tbl[i].d       = (i < 12) ? 32'(i + 1) : ((i == 18) ? 32'd77 : 32'(100 + i));
            tbl[i].last    = (i == 11);
            tbl[i].a       = (i == 17);
            tbl[i].exp_rdy = !(i >= 11 && i <= 16);
            tbl[i].exp_en  = (i >= 11 && i <= 16);
            tbl[i].exp_cnt = (i >= 17) ? 16'd1 : 16'd0;
        end
        for (int k = 0; k < N; k++) begin
            e1[k*32 +: 32] = 32'(k + 1);
            e2[k*32 +: 32] = 32'(k + 7);
        end

        fl = 0; sv = 0; sd = 0; sl = 0; ack = 0;
        fl1 = 0; sv1 = 0; sd1 = 0; sl1 = 0; ack1 = 0;
        model_reset();
        #12;
        compare_all("in_reset");
        rst_n = 1'b1;
        cyc("first_edge", 0, 0, 0, 0, 0);
        check("rdy_after_reset", srdy, 1'b1);

        // Back-to-back 1..12, hold with s_valid high, then en_ack and a new word.
        for (int i = 0; i < 19; i++) begin
            cyc("tbl", tbl[i].v, tbl[i].d, tbl[i].last, tbl[i].a, 1'b0);
            check("tbl.rdy", srdy, tbl[i].exp_rdy);
            check("tbl.en", en, tbl[i].exp_en);
            check("tbl.cnt", cnt, tbl[i].exp_cnt);
            if (i == 11 || i == 17) begin
                check("tbl.in1_1to6", i1, e1);
                check("tbl.in2_7to12", i2, e2);
            end
        end
        check("next_pair.in1_00", i1[31:0], 32'd77);
        check("next_pair.in1_01_kept", i1[63:32], 32'd2);

        // Flush after 4 accepts; the word presented with flush is dropped.
        cyc("fl_pre", 0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) cyc("fl_acc", 1, 32'(200 + k), 0, 0, 0);
        cyc("fl", 1, 32'hDEAD, 0, 1, 1);
        check("flush.cnt", cnt, 16'd1);
        check("flush.in1_kept", i1[4*32-1:0], {32'd203, 32'd202, 32'd201, 32'd200});
        for (int k = 0; k < 12; k++) cyc("fl_fresh", 1, 32'(300 + k), k == 11, 0, 0);
        check("fresh.in1_00", i1[31:0], 32'd300);
        check("fresh.in2_00", i2[31:0], 32'd306);
        check("fresh.en", en, 1'b1);
        cyc("fl_ack", 0, 0, 0, 1, 0);
        check("fl_ack.cnt", cnt, 16'd2);

        // Framing: s_last wrongly set on the 5th accept.
        for (int k = 0; k < 12; k++) begin
            cyc("frm", 1, 32'(400 + k), (k == 4) || (k == 11), 0, 0);
            if (k == 4) check("frm.err_5th", err, FC);
        end
        check("frm.err_sticky", err, FC);
        check("frm.en", en, 1'b1);
        cyc("frm_ack", 0, 0, 0, 1, 0);
        check("frm.err_after_ack", err, FC);
        cyc("frm_flush", 0, 0, 0, 0, 1);
        check("frm.err_cleared", err, 1'b0);

        // Asynchronous reset in LOAD_B with idx=2.
        for (int k = 0; k < 8; k++) cyc("rst_pre", 1, 32'(500 + k), 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("arst.in1", i1, '0);
        check("arst.in2", i2, '0);
        check("arst.en", en, 1'b0);
        check("arst.rdy", srdy, 1'b0);
        check("arst.cnt", cnt, 16'd0);
        check("arst.err", err, 1'b0);
        model_reset();
        #1;
        rst_n = 1'b1;
        #1;
        check("arst.rdy_before_edge", srdy, 1'b0);
        for (int k = 0; k < 10; k++) cyc("rst_idle", 0, 0, 0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            cyc("rst_reload", 1, 32'(600 + k), k == 11, 0, 0);
            if (k == 10) check("reload.no_en_at_11", en, 1'b0);
        end
        check("reload.en_at_12", en, 1'b1);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            bit v, a, f, lst;
            v   = ($urandom_range(0, 9) < 7);
            a   = ($urandom_range(0, 9) < 3);
            f   = ($urandom_range(0, 49) == 0);
            lst = (pos == 2*N-1) ^ ($urandom_range(0, 19) == 0);
            cyc("rnd", v, $urandom, lst, a, f);
        end

        // 1x1 instance: extreme data, then load_cnt wrap.
        sv1 = 1; sd1 = 32'hFFFF_FFFF; sl1 = 0; ack1 = 0;
        tick1();
        check("n1.in1", i1_1, 32'hFFFF_FFFF);
        check("n1.en_after_1", en1, 1'b0);
        check("n1.rdy_after_1", srdy1, 1'b1);
        sd1 = 32'h1; sl1 = 1;
        tick1();
        check("n1.in2", i2_1, 32'h1);
        check("n1.in1_kept", i1_1, 32'hFFFF_FFFF);
        check("n1.en_after_2", en1, 1'b1);
        check("n1.rdy_hold", srdy1, 1'b0);
        sv1 = 0; ack1 = 1;
        tick1();
        check("n1.cnt_1", cnt1, 16'd1);
        sv1 = 1;
        for (int p = 2; p <= 65535; p++) begin
            sd1 = 32'(p); sl1 = 0; tick1();
            sl1 = 1; tick1();
            tick1();
        end
        check("n1.cnt_ffff", cnt1, 16'hFFFF);
        sl1 = 0; tick1();
        sl1 = 1; tick1();
        check("n1.en_last", en1, 1'b1);
        check("n1.cnt_before_wrap", cnt1, 16'hFFFF);
        sv1 = 0; tick1();
        check("n1.cnt_wrap", cnt1, 16'h0000);
        check("n1.en_cleared", en1, 1'b0);
        check("n1.err", err1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
